// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared constants for the MMIO peripheral slice:
//   - byte offsets of every register inside the 32-byte peripheral window
//   - TCON bit positions
//   - DIGI reset value (all anodes off, segments cleared)
// -----------------------------------------------------------------------------
package mmio_pkg;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_SWITCH  = 5'h10;
    localparam logic [4:0] OFF_DIGI    = 5'h14;
    localparam logic [4:0] OFF_SYSTICK = 5'h18;

    localparam int TCON_EN = 0;  // timer enable
    localparam int TCON_IE = 1;  // interrupt enable
    localparam int TCON_IS = 2;  // interrupt status

    localparam logic [11:0] DIGI_RST = 12'hF00;

endpackage

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
// Reloading 32-bit timer with interrupt. TL counts up while enabled and, instead
// of wrapping, reloads from TH; the reload sets the interrupt status bit when
// interrupts are enabled. CPU writes always take priority over hardware updates.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   wr_th    in   CPU write strobe for TH
//   wr_tl    in   CPU write strobe for TL
//   wr_tcon  in   CPU write strobe for TCON
//   wdata    in   CPU store data (32)
//   th       out  TH register (32)
//   tl       out  TL register (32)
//   tcon     out  TCON register (3)
//   irqout   out  interrupt request = TCON.IE & TCON.IS
// -----------------------------------------------------------------------------
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irqout
);

    logic rollover;

    // Reload happens on the edge after TL reaches all-ones with the timer running.
    assign rollover = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
        end else if (wr_th) begin
            th <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl <= '0;
        end else if (wr_tl) begin
            tl <= wdata;
        end else if (tcon[TCON_EN]) begin
            tl <= rollover ? th : (tl + 32'd1);
        end
    end

    // A CPU write to TL cancels the reload, so no interrupt is raised for it.
    // A CPU write to TCON replaces the whole register, including the status bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon <= '0;
        end else if (wr_tcon) begin
            tcon <= wdata[2:0];
        end else if (rollover && tcon[TCON_IE] && !wr_tl) begin
            tcon[TCON_IS] <= 1'b1;
        end
    end

    assign irqout = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/mmio_peripheral.sv
// -----------------------------------------------------------------------------
// mmio_peripheral
// Memory-mapped peripheral block: timer, LEDs, switches, 7-segment display and
// an optional free-running system tick counter, in a 32-byte window at
// BASE_ADDR. Loads are combinational; stores take effect on the rising edge.
//
// Build option:
//   MMIO_SYSTICK_EN  when defined, SYSTICK (offset 0x18) is a free-running
//                    32-bit counter; otherwise it has no storage and reads 0.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   Address     in   CPU byte address (32), bits [1:0] ignored
//   Write_data  in   CPU store data (32)
//   MemRead     in   load strobe
//   MemWrite    in   store strobe
//   Read_data   out  load data (32), combinational, 0 when not addressed
//   switch      in   board switches (8), read live
//   led         out  board LEDs (8)
//   digi        out  7-segment drive (12): [7:0] segments, [11:8] anodes (act. low)
//   irqout      out  timer interrupt request
// -----------------------------------------------------------------------------
module mmio_peripheral
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout
);

    logic [31:0] offset;
    logic        in_win;
    logic [4:0]  reg_off;
    logic        wr_hit;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;

    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic [7:0]  led_reg;
    logic [11:0] digi_reg;

    // Subtracting the base makes the decode independent of base alignment.
    assign offset  = Address - BASE_ADDR;
    assign in_win  = (offset[31:5] == 27'd0);
    assign reg_off = offset[4:0] & 5'b11100;

    assign wr_hit  = MemWrite && in_win;
    assign wr_th   = wr_hit && (reg_off == OFF_TH);
    assign wr_tl   = wr_hit && (reg_off == OFF_TL);
    assign wr_tcon = wr_hit && (reg_off == OFF_TCON);
    assign wr_led  = wr_hit && (reg_off == OFF_LED);
    assign wr_digi = wr_hit && (reg_off == OFF_DIGI);

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_th),
        .wr_tl   (wr_tl),
        .wr_tcon (wr_tcon),
        .wdata   (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irqout  (irqout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_reg <= '0;
        end else if (wr_led) begin
            led_reg <= Write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digi_reg <= DIGI_RST;
        end else if (wr_digi) begin
            digi_reg <= Write_data[11:0];
        end
    end

`ifdef MMIO_SYSTICK_EN
    logic [31:0] systick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    assign led  = led_reg;
    assign digi = digi_reg;

    always_comb begin
        Read_data = '0;
        if (MemRead && in_win) begin
            case (reg_off)
                OFF_TH:      Read_data = th;
                OFF_TL:      Read_data = tl;
                OFF_TCON:    Read_data = {29'd0, tcon};
                OFF_LED:     Read_data = {24'd0, led_reg};
                OFF_SWITCH:  Read_data = {24'd0, switch};
                OFF_DIGI:    Read_data = {20'd0, digi_reg};
`ifdef MMIO_SYSTICK_EN
                OFF_SYSTICK: Read_data = systick;
`else
                OFF_SYSTICK: Read_data = '0;
`endif
                default:     Read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_peripheral.sv
// -----------------------------------------------------------------------------
// tb_mmio_peripheral
// Self-checking bench for mmio_peripheral: a vector table for the simple
// register-access cases, hand-written sequences for the timer corner cases and
// reset, then randomized traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mmio_peripheral;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_SYS  = BASE + 32'h18;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Read_data;
    logic [7:0]  switch = '0;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    int checks = 0;
    int failures = 0;

    mmio_peripheral #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .switch     (switch),
        .led        (led),
        .digi       (digi),
        .irqout     (irqout)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_th, m_tl, m_sys;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    task automatic model_reset();
        m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_digi = 12'hF00; m_sys = '0;
    endtask

    function automatic logic [31:0] model_read(input bit re, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!re || off >= 32) return 32'd0;
        case (off[4:2])
            3'd0: return m_th;
            3'd1: return m_tl;
            3'd2: return {29'd0, m_tcon};
            3'd3: return {24'd0, m_led};
            3'd4: return {24'd0, switch};
            3'd5: return {20'd0, m_digi};
`ifdef MMIO_SYSTICK_EN
            3'd6: return m_sys;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One bus cycle, entered and left at a falling edge. Read data is checked
    // before the rising edge; registered outputs just after it.
    task automatic cycle(input bit we, input bit re, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] off, n_th, n_tl;
        logic [2:0]  n_tcon;
        logic [7:0]  n_led;
        logic [11:0] n_digi;
        bit          hit, reload;
        MemWrite = we; MemRead = re; Address = a; Write_data = d;
        #1;
        rd = Read_data;
        chk("model_rd", rd, model_read(re, a));
        off    = a - BASE;
        hit    = we && (off < 32);
        reload = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        n_th = m_th; n_led = m_led; n_digi = m_digi; n_tcon = m_tcon;
        n_tl = !m_tcon[0] ? m_tl : (reload ? m_th : m_tl + 1);
        if (reload && m_tcon[1] && !(hit && off[4:2] == 3'd1)) n_tcon[2] = 1'b1;
        if (hit) begin
            case (off[4:2])
                3'd0: n_th   = d;
                3'd1: n_tl   = d;
                3'd2: n_tcon = d[2:0];
                3'd3: n_led  = d[7:0];
                3'd5: n_digi = d[11:0];
                default: ;
            endcase
        end
        @(posedge clk);
        m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_led = n_led; m_digi = n_digi;
        m_sys = m_sys + 1;
        #1;
        chk("model_led", {24'd0, led}, {24'd0, m_led});
        chk("model_digi", {20'd0, digi}, {20'd0, m_digi});
        chk("model_irq", {31'd0, irqout}, {31'd0, m_tcon[1] & m_tcon[2]});
        MemWrite = 1'b0; MemRead = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
        logic [11:0] exp_digi;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, d;
        bit we, re;

        vecs[0]  = '{1, 0, 32'h4000000C, 32'h12345678, 8'h00, 32'h0,        8'h78, 12'hF00};
        vecs[1]  = '{1, 0, 32'h40000010, 32'hFFFFFFFF, 8'h00, 32'h0,        8'h78, 12'hF00};
        vecs[2]  = '{0, 1, 32'h40000010, 32'h0,        8'hA5, 32'h000000A5, 8'h78, 12'hF00};
        vecs[3]  = '{0, 1, 32'h4000001C, 32'h0,        8'hA5, 32'h0,        8'h78, 12'hF00};
        vecs[4]  = '{0, 0, 32'h4000000C, 32'h0,        8'hA5, 32'h0,        8'h78, 12'hF00};
        vecs[5]  = '{1, 0, 32'h40000014, 32'h00000E3F, 8'hA5, 32'h0,        8'h78, 12'hE3F};
        vecs[6]  = '{0, 1, 32'h4000000C, 32'h0,        8'hA5, 32'h00000078, 8'h78, 12'hE3F};
        vecs[7]  = '{0, 1, 32'h40000016, 32'h0,        8'hA5, 32'h00000E3F, 8'h78, 12'hE3F};
        vecs[8]  = '{1, 0, 32'h4000002C, 32'h0,        8'hA5, 32'h0,        8'h78, 12'hE3F};
        vecs[9]  = '{1, 0, 32'h3FFFFFFC, 32'h0,        8'hA5, 32'h0,        8'h78, 12'hE3F};
        vecs[10] = '{0, 1, 32'h4000000D, 32'h0,        8'h5A, 32'h00000078, 8'h78, 12'hE3F};
        vecs[11] = '{0, 1, 32'h40000010, 32'h0,        8'h5A, 32'h0000005A, 8'h78, 12'hE3F};

        // Reset state
        model_reset();
        MemRead = 1'b1; Address = A_TL;
        #12;
        chk("rst_irq", {31'd0, irqout}, 32'd0);
        chk("rst_led", {24'd0, led}, 32'd0);
        chk("rst_digi", {20'd0, digi}, 32'h00000F00);
        chk("rst_rd", Read_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        MemRead = 1'b0;

        // Table-driven register accesses
        foreach (vecs[i]) begin
            switch = vecs[i].sw;
            cycle(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, rd);
            chk($sformatf("tbl%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("tbl%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
            chk($sformatf("tbl%0d_digi", i), {20'd0, digi}, {20'd0, vecs[i].exp_digi});
        end

        // Timer reload and interrupt
        cycle(1, 0, A_TH,   32'hFFFFFFFD, rd);
        cycle(1, 0, A_TL,   32'hFFFFFFFE, rd);
        cycle(1, 0, A_TCON, 32'h3, rd);
        cycle(0, 0, A_TH, 0, rd);
        cycle(0, 0, A_TH, 0, rd);
        chk("reload_irq", {31'd0, irqout}, 32'd1);
        cycle(0, 1, A_TL, 0, rd);
        chk("reload_tl", rd, 32'hFFFFFFFD);
        cycle(0, 1, A_TCON, 0, rd);
        chk("reload_tcon", rd, 32'h7);

        // CPU write of TCON clears status and wins over a coincident reload
        cycle(1, 0, A_TCON, 32'h3, rd);
        chk("clr_irq", {31'd0, irqout}, 32'd0);
        cycle(0, 1, A_TL, 0, rd);
        chk("clr_tl0", rd, 32'hFFFFFFFD);
        cycle(0, 1, A_TL, 0, rd);
        chk("clr_tl1", rd, 32'hFFFFFFFE);

        // CPU write of TL wins over a coincident reload, no status set
        cycle(1, 0, A_TL, 32'h5, rd);
        cycle(0, 1, A_TL, 0, rd);
        chk("tlwin_tl", rd, 32'h5);
        cycle(0, 1, A_TCON, 0, rd);
        chk("tlwin_tcon", rd, 32'h3);

        // Timer disabled: TL holds
        cycle(1, 0, A_TCON, 32'h2, rd);
        cycle(0, 1, A_TL, 0, rd);
        chk("hold_tl0", rd, 32'h8);
        cycle(0, 1, A_TL, 0, rd);
        chk("hold_tl1", rd, 32'h8);

        // Asynchronous reset in the middle of a count with a pending interrupt
        cycle(1, 0, A_TCON, 32'h7, rd);
        chk("pre_rst_irq", {31'd0, irqout}, 32'd1);
        cycle(0, 0, A_TH, 0, rd);
        MemRead = 1'b1; Address = A_TL;
        #2 reset = 1'b0;
        #1;
        chk("arst_irq", {31'd0, irqout}, 32'd0);
        chk("arst_tl", Read_data, 32'd0);
        chk("arst_digi", {20'd0, digi}, 32'h00000F00);
        chk("arst_led", {24'd0, led}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        MemRead = 1'b0;

        // SYSTICK
        cycle(0, 1, A_SYS, 0, rd);
`ifdef MMIO_SYSTICK_EN
        chk("sys_0", rd, 32'd0);
        repeat (4) cycle(0, 0, A_TH, 0, rd);
        cycle(0, 1, A_SYS, 0, rd);
        chk("sys_5", rd, 32'd5);
`else
        chk("sys_off", rd, 32'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0)
                a = BASE + 32'd32 + $urandom_range(0, 255);
            else
                a = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            we = ($urandom_range(0, 2) == 0);
            re = $urandom_range(0, 1);
            d  = $urandom;
            if ((a - BASE) < 32 && (a - BASE) >= 4 && (a - BASE) < 8)
                d = 32'hFFFFFFF0 + $urandom_range(0, 15);
            if ((a - BASE) < 4 && $urandom_range(0, 1) == 1)
                d = 32'hFFFFFFF8 + $urandom_range(0, 7);
            switch = 8'($urandom);
            cycle(we, re, a, d, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
